// File: rtl/digit_scan_driver.sv
// Four-digit seven-segment scan driver: cycles the digit index, decodes BCD onto the
// shared active-low segment bus, inserts blanking guards and flags each completed frame.
//
// state | meaning
// IDLE  | scan stopped, all outputs at reset values
// SHOW  | current digit lit for CLK_DIV cycles
// GUARD | all segments and enables off for GUARD_CYCLES cycles, sel already on next digit
module digit_scan_driver #(
    parameter int CLK_DIV      = 50000,
    parameter int GUARD_CYCLES = 4,
    parameter int LZ_BLANK     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] dp_in,
    output logic [0:1] sel,
    output logic [3:0] dig_en_n,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic       frame_done
);

    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int GUARD_W = (GUARD_CYCLES > 2) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam bit LZ_ON = (LZ_BLANK != 0);

    typedef enum logic [1:0] {IDLE, SHOW, GUARD} state_t;

    state_t              state;
    logic [1:0]          index;
    logic [DIV_W-1:0]    div_cnt;
    logic [GUARD_W-1:0]  guard_cnt;

    logic [3:0] cur_bcd;
    logic       cur_dp;
    logic       suppress;
    logic [6:0] seg_dec;
    logic [3:0] lit_en_n;

    always_comb begin
        cur_bcd  = digit0;
        cur_dp   = dp_in[index];
        suppress = 1'b0;
        case (index)
            2'd0: cur_bcd = digit0;
            2'd1: begin
                cur_bcd  = digit1;
                suppress = LZ_ON && (digit3 == 4'd0) && (digit2 == 4'd0) && (digit1 == 4'd0);
            end
            2'd2: begin
                cur_bcd  = digit2;
                suppress = LZ_ON && (digit3 == 4'd0) && (digit2 == 4'd0);
            end
            default: begin
                cur_bcd  = digit3;
                suppress = LZ_ON && (digit3 == 4'd0);
            end
        endcase
        lit_en_n = ~(4'b0001 << index);
    end

    // Non-BCD codes blank the segments but keep the digit enable asserted.
    always_comb begin
        case (cur_bcd)
            4'd0:    seg_dec = 7'b1000000;
            4'd1:    seg_dec = 7'b1111001;
            4'd2:    seg_dec = 7'b0100100;
            4'd3:    seg_dec = 7'b0110000;
            4'd4:    seg_dec = 7'b0011001;
            4'd5:    seg_dec = 7'b0010010;
            4'd6:    seg_dec = 7'b0000010;
            4'd7:    seg_dec = 7'b1111000;
            4'd8:    seg_dec = 7'b0000000;
            4'd9:    seg_dec = 7'b0010000;
            default: seg_dec = 7'h7F;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            index      <= 2'd0;
            div_cnt    <= '0;
            guard_cnt  <= '0;
            sel        <= 2'b00;
            dig_en_n   <= 4'b1111;
            seg_n      <= 7'h7F;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else if (!en) begin
            state      <= IDLE;
            index      <= 2'd0;
            div_cnt    <= '0;
            guard_cnt  <= '0;
            sel        <= 2'b00;
            dig_en_n   <= 4'b1111;
            seg_n      <= 7'h7F;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            // sel follows the index one edge later, so a 3->0 step of sel marks the frame end.
            frame_done <= (state != IDLE) && (sel == 2'b11) && (index == 2'd0);
            case (state)
                IDLE: begin
                    state     <= SHOW;
                    index     <= 2'd0;
                    div_cnt   <= '0;
                    guard_cnt <= '0;
                    sel       <= 2'b00;
                    dig_en_n  <= 4'b1111;
                    seg_n     <= 7'h7F;
                    dp_n      <= 1'b1;
                end
                SHOW: begin
                    sel <= index;
                    if (suppress) begin
                        dig_en_n <= 4'b1111;
                        seg_n    <= 7'h7F;
                        dp_n     <= 1'b1;
                    end else begin
                        dig_en_n <= lit_en_n;
                        seg_n    <= seg_dec;
                        dp_n     <= ~cur_dp;
                    end
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        index   <= index + 2'd1;
                        if (GUARD_CYCLES > 0) begin
                            state     <= GUARD;
                            guard_cnt <= '0;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                GUARD: begin
                    sel      <= index;
                    dig_en_n <= 4'b1111;
                    seg_n    <= 7'h7F;
                    dp_n     <= 1'b1;
                    if (guard_cnt == GUARD_LAST) begin
                        guard_cnt <= '0;
                        state     <= SHOW;
                    end else begin
                        guard_cnt <= guard_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_scan_driver.sv
// Bench for digit_scan_driver: two parameterisations checked every cycle against a
// frame-position model (slot = time / slot length), plus directed test-plan scenarios.
module tb_digit_scan_driver;

    localparam int DA = 4, GA = 2, LZA = 1;
    localparam int DB = 3, GB = 0, LZB = 0;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] den;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } obs_t;

    localparam obs_t RST = '{sel: 2'b00, den: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] digit0 = 4'd0, digit1 = 4'd0, digit2 = 4'd0, digit3 = 4'd0;
    logic [3:0] dp_in = 4'd0;

    logic [0:1] sel_a, sel_b;
    logic [3:0] den_a, den_b;
    logic [6:0] seg_a, seg_b;
    logic       dpn_a, dpn_b, fd_a, fd_b;

    obs_t obs_a, obs_b;
    assign obs_a = {sel_a[0], sel_a[1], den_a, seg_a, dpn_a, fd_a};
    assign obs_b = {sel_b[0], sel_b[1], den_b, seg_b, dpn_b, fd_b};

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit active = 1'b0;
    int n = 0;

    always #5 clk = ~clk;

    digit_scan_driver #(.CLK_DIV(DA), .GUARD_CYCLES(GA), .LZ_BLANK(LZA)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3), .dp_in(dp_in),
        .sel(sel_a), .dig_en_n(den_a), .seg_n(seg_a), .dp_n(dpn_a), .frame_done(fd_a));

    digit_scan_driver #(.CLK_DIV(DB), .GUARD_CYCLES(GB), .LZ_BLANK(LZB)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3), .dp_in(dp_in),
        .sel(sel_b), .dig_en_n(den_b), .seg_n(seg_b), .dp_n(dpn_b), .frame_done(fd_b));

    function automatic logic [6:0] dec(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    // t = output cycle number since the first lit cycle of the scan.
    function automatic obs_t model(input int d, input int g, input int lz, input int t,
                                   input logic [15:0] digs, input logic [3:0] dps);
        obs_t o;
        int p, tt, slot, w;
        bit sup;
        o = RST;
        p = 4 * (d + g);
        tt = t % p;
        slot = tt / (d + g);
        w = tt % (d + g);
        if (w < d) begin
            o.sel = 2'(slot);
            sup = (lz != 0) && (slot > 0);
            for (int j = slot; j < 4; j++)
                if (digs[4*j +: 4] != 4'd0) sup = 1'b0;
            if (!sup) begin
                o.den = ~(4'b0001 << slot);
                o.seg = dec(digs[4*slot +: 4]);
                o.dp  = ~dps[slot];
            end
        end else begin
            o.sel = 2'((slot + 1) % 4);
        end
        o.fd = (t > 0) && (tt == (3 * (d + g) + d) % p);
        return o;
    endfunction

    task automatic check(input string tag, input obs_t got, input obs_t exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d sel got %0d exp %0d, den got %b exp %b, seg got %b exp %b, dp got %b exp %b, fd got %b exp %b",
                   tag, cyc, got.sel, exp.sel, got.den, exp.den, got.seg, exp.seg,
                   got.dp, exp.dp, got.fd, exp.fd);
        end
    endtask

    task automatic tick();
        obs_t ea, eb;
        logic [15:0] digs;
        digs = {digit3, digit2, digit1, digit0};
        if (!rst_n || !en) begin
            active = 1'b0;
            ea = RST;
            eb = RST;
        end else if (!active) begin
            active = 1'b1;
            n = 0;
            ea = RST;
            eb = RST;
        end else begin
            ea = model(DA, GA, LZA, n, digs, dp_in);
            eb = model(DB, GB, LZB, n, digs, dp_in);
            n++;
        end
        @(posedge clk);
        #1;
        cyc++;
        check("dut_a", obs_a, ea);
        check("dut_b", obs_b, eb);
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                              input logic [3:0] d1, input logic [3:0] d0);
        digit3 = d3; digit2 = d2; digit1 = d1; digit0 = d0;
    endtask

    task automatic expect_true(input string tag, input bit cond, input int got, input int exp);
        checks++;
        assert (cond) else begin
            errors++;
            $error("FAIL %s cyc=%0d got %0d exp %0d", tag, cyc, got, exp);
        end
    endtask

    initial begin
        int c0, c1, k;

        // 1. reset with en high, then start
        set_digits(4'd0, 4'd0, 4'd0, 4'd5);
        en = 1'b1;
        ticks(2);
        check("reset_a", obs_a, RST);
        rst_n = 1'b1;
        tick();
        tick();
        expect_true("start_den", den_a === 4'b1110, den_a, 4'b1110);
        expect_true("start_seg", seg_a === 7'b0010010, seg_a, 7'b0010010);

        // 2. scan order and frame period
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        k = 0;
        while (k < 60 && !fd_a) begin tick(); k++; end
        expect_true("wait_fd1", fd_a === 1'b1, k, 60);
        c0 = cyc;
        tick();
        k = 0;
        while (k < 60 && !fd_a) begin tick(); k++; end
        c1 = cyc;
        expect_true("frame_period", fd_a === 1'b1 && (c1 - c0) == 4 * (DA + GA), c1 - c0, 4 * (DA + GA));
        expect_true("fd_sel_zero", {sel_a[0], sel_a[1]} == 2'b00, {sel_a[0], sel_a[1]}, 0);
        ticks(24);

        // 3. leading-zero suppression
        set_digits(4'd0, 4'd0, 4'd7, 4'd0);
        ticks(30);
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        ticks(30);

        // 4. invalid BCD and decimal point
        set_digits(4'd1, 4'hC, 4'd3, 4'd4);
        dp_in = 4'b0100;
        ticks(30);
        dp_in = 4'b0000;

        // 5. enable drop during slot 2
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        k = 0;
        while (k < 40 && den_a !== 4'b1011) begin tick(); k++; end
        expect_true("wait_slot2", den_a === 4'b1011, k, 40);
        en = 1'b0;
        tick();
        check("en_drop_a", obs_a, RST);
        en = 1'b1;
        ticks(30);

        // 6. async reset while in a guard slot
        k = 0;
        while (k < 40 && !(den_a === 4'hF && {sel_a[0], sel_a[1]} == 2'd2)) begin tick(); k++; end
        expect_true("wait_guard", den_a === 4'hF, k, 40);
        #2 rst_n = 1'b0;
        #1;
        active = 1'b0;
        check("async_rst_a", obs_a, RST);
        check("async_rst_b", obs_b, RST);
        tick();
        rst_n = 1'b1;
        ticks(30);

        // 7. randomized digits, decimal points and occasional enable drops
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                digit0 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                digit1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                digit2 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                digit3 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                dp_in  = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 59) == 0) en = ~en;
            else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
